accel_sweep_wrapper: RTL
========================

// Module: accel_sweep_wrapper
// PURPOSE
//  Parametrised successor of the accelerator wrapper. On start, sweeps x = 0..V and computes
//  x^(U+1) per step with a sequential multiplier. Results go through a FIFO with valid/ready
//  write handshake (wr_req/wr_ready) to the downstream memory writer. Sits between the
//  control/test driver and the result memory.
// PARAMETERS
//  VW          5    width of V and sweep index x
//  UW          2    width of U; exponent e = U+1, range 1..2^UW
//  RW          20   result width; default VW*2^UW never overflows
//  FIFO_DEPTH  4    output FIFO entries, power of 2, >= 2
// PORTS
//  clk       in   1      single clock, rising edge
//  rst       in   1      asynchronous, active-low reset (0 = reset)
//  start     in   1      level sampled in IDLE; rising in IDLE launches a sweep
//  U         in   UW     exponent select, captured at start
//  V         in   VW     last sweep index (inclusive), captured at start
//  wr_ready  in   1      downstream accepts wr_data this cycle
//  busy      out  1      sweep in progress, or FIFO not yet drained
//  done      out  1      one-cycle pulse when the last result has been popped
//  wr_req    out  1      FIFO non-empty; wr_data valid
//  wr_data   out  RW+1   {ovf, result[RW-1:0]} from the FIFO head
// BEHAVIOUR
//  - Reset (async, rst=0): FSM->IDLE, x/acc/k cleared, FIFO emptied. busy=0, done=0, wr_req=0, wr_data=0.
//  - FSM: IDLE -> LOAD -> MUL -> PUSH -> (LOAD | DRAIN) -> DONE -> IDLE.
//  - IDLE: if start=1, capture U_r=U and V_r=V. Set x=0. Next state LOAD. busy=1 from the next cycle.
//  - LOAD (1 cycle): acc=1, k=0, ovf_r=0.
//  - MUL (e cycles): each cycle prod = acc*x (RW+VW bits) and k++.
//      If prod[RW+VW-1:RW] != 0, or ovf_r is already set: acc = {RW{1'b1}} (saturate), ovf_r=1.
//      Otherwise acc = prod[RW-1:0].
//      Leave MUL after k reaches e.
//  - PUSH: if FIFO not full, write {ovf_r, acc}.
//      Then if x==V_r go DRAIN; else x++ and go LOAD.
//      If FIFO full, hold in PUSH (stall). No data is lost.
//  - Throughput: e+2 cycles per result without backpressure.
//  - DRAIN: wait for FIFO empty, then DONE.
//  - DONE: done=1 for exactly 1 cycle, busy=0 in the same cycle, then IDLE.
//  - FIFO output: wr_req = !empty. wr_data = head entry (0 when empty).
//      Pop on wr_req & wr_ready.
//      Simultaneous push+pop when full: the push is blocked that cycle (full is registered); the pop proceeds.
//      Simultaneous push+pop when non-full: both happen, count unchanged.
//  - start is ignored outside IDLE. A new start is accepted the cycle after DONE.
//  - x is compared against V_r before incrementing, so V = 2^VW-1 gives no wrap.
//  - V=0 gives exactly one result.
//  - Reset mid-sweep aborts immediately: no done pulse, FIFO contents discarded.
// STRUCTURE
//  - Package accel_pkg holds:
//      state enum {IDLE, LOAD, MUL, PUSH, DRAIN, DONE};
//      function clog2-based PTR_W;
//      localparam DEF_RW(VW, UW) = VW<<UW.
//  - Sub-module accel_result_fifo #(W=RW+1, DEPTH=FIFO_DEPTH):
//      sync FIFO, registered full/empty, same clk and async active-low rst.
//  - Top level: FSM, x/k counters, acc datapath with saturation.
// TESTING
//  1. Hold rst=0 with random inputs -> busy=0, done=0, wr_req=0, wr_data=0 throughout.
//     Release -> IDLE, no writes.
//  2. U=1, V=3, wr_ready=1 -> wr_data ovf=0 results 0, 1, 4, 9 in order.
//     done pulses once, 1 cycle after the last pop. busy falls with done.
//  3. U=3, V=31, RW=20 -> 32 results; last = 923521, ovf=0.
//     Same with RW=16 -> x=15 gives 50625, ovf=0; x>=16 gives 0xFFFF, ovf=1.
//  4. U=0, V=7, wr_ready=0 for 60 cycles -> exactly FIFO_DEPTH (4) entries held, wr_req=1, FSM stalled in PUSH.
//     Then wr_ready=1 -> 0..7 delivered in order, none dropped or duplicated.
//  5. U=2, V=0 -> single word 0 then done.
//     start re-asserted mid-sweep with different U/V -> ignored, outputs unchanged.
//  6. rst=0 asynchronously mid-MUL of U=3, V=10 -> wr_req, busy, done low before the next clk edge.
//     Fresh start after release -> full correct sweep.

Source files
------------

// File: rtl/accel_pkg.sv
// Shared types and width helpers for the power-sweep accelerator wrapper.
package accel_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        MUL   = 3'd2,
        PUSH  = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } state_t;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Result width large enough that x^e never saturates for x < 2^VW, e <= 2^UW.
    function automatic int def_rw(input int vw, input int uw);
        return vw << uw;
    endfunction

endpackage

// File: rtl/accel_result_fifo.sv
// Synchronous result FIFO with registered full/empty; head reads as zero when empty.
module accel_result_fifo
    import accel_pkg::*;
#(
    parameter int W     = 21,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    localparam int PW = ptr_w(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic [PW:0]   count_next;
    logic          push_ok;
    logic          pop_ok;

    // Flags are registered, so a push into a full FIFO is refused even if a pop frees a slot.
    assign push_ok = wr_en && !full;
    assign pop_ok  = rd_en && !empty;

    always_comb begin
        count_next = count;
        if (push_ok && !pop_ok)
            count_next = count + 1'b1;
        else if (pop_ok && !push_ok)
            count_next = count - 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            full  <= (count_next == FULL_CNT);
            empty <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= wr_data;
    end

    assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/accel_sweep_wrapper.sv
// Sweeps x = 0..V computing x^(U+1) with a one-multiply-per-cycle datapath, streaming
// saturating results through a FIFO to the memory writer.
module accel_sweep_wrapper
    import accel_pkg::*;
#(
    parameter int VW         = 5,
    parameter int UW         = 2,
    parameter int RW         = def_rw(VW, UW),
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [UW-1:0] U,
    input  logic [VW-1:0] V,
    input  logic          wr_ready,
    output logic          busy,
    output logic          done,
    output logic          wr_req,
    output logic [RW:0]   wr_data,
    output logic [2:0]    state_dbg
);

    // wr_req/wr_ready form a valid/ready pair: wr_data is stable while wr_req is high and
    // not yet accepted; a word transfers on any rising edge where both are high.

    state_t           state;
    logic [UW-1:0]    u_r;
    logic [VW-1:0]    v_r;
    logic [VW-1:0]    x;
    logic [RW-1:0]    acc;
    logic             ovf_r;
    logic [UW:0]      k;
    logic [UW:0]      e;
    logic [RW+VW-1:0] prod;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;

    assign e    = {1'b0, u_r} + {{UW{1'b0}}, 1'b1};
    assign prod = {{VW{1'b0}}, acc} * {{RW{1'b0}}, x};
    assign push = (state == PUSH) && !fifo_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            u_r   <= '0;
            v_r   <= '0;
            x     <= '0;
            acc   <= '0;
            ovf_r <= 1'b0;
            k     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        u_r   <= U;
                        v_r   <= V;
                        x     <= '0;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    acc   <= {{(RW-1){1'b0}}, 1'b1};
                    k     <= '0;
                    ovf_r <= 1'b0;
                    state <= MUL;
                end
                MUL: begin
                    k <= k + 1'b1;
                    // Once saturated, stay saturated even if a later factor is zero-free.
                    if (prod[RW+VW-1:RW] != '0 || ovf_r) begin
                        acc   <= '1;
                        ovf_r <= 1'b1;
                    end else begin
                        acc <= prod[RW-1:0];
                    end
                    if ((k + 1'b1) == e)
                        state <= PUSH;
                end
                PUSH: begin
                    if (!fifo_full) begin
                        if (x == v_r) begin
                            state <= DRAIN;
                        end else begin
                            x     <= x + 1'b1;
                            state <= LOAD;
                        end
                    end
                end
                DRAIN: begin
                    if (fifo_empty) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    accel_result_fifo #(
        .W     (RW + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data ({ovf_r, acc}),
        .rd_en   (wr_ready),
        .rd_data (wr_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign wr_req    = !fifo_empty;
    assign state_dbg = state;

endmodule
